// File: rtl/buffer_controller_mc_pkg.sv
// buffer_controller_mc_pkg: shared state encodings, status bit positions and channel-select width
package buffer_controller_mc_pkg;
  typedef enum logic [1:0] {IDLE, PRE_LOADING, WAITING_TRIGGER, POST_LOADING} state_t;
  typedef enum logic {S_IDLE, S_SENDING} stat_state_t;
  localparam int ST_BUFFER_FULL = 0;
  localparam int ST_TRIGGERED = 1;
  localparam int ST_IDLE = 2;
  localparam int ST_AUTO_FIRED = 3;
  function automatic int ch_sel_bits(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/buffer_controller_mc_if.sv
// buffer_controller_mc_if: one-byte status frame handshake between the controller and tx_control
interface buffer_controller_mc_if;
  logic       rqst_trigger_status;
  logic [7:0] trigger_status_data;
  logic       trigger_status_rdy;
  logic       trigger_status_eof;
  logic       trigger_status_ack;
  modport master (
    input  rqst_trigger_status, trigger_status_ack,
    output trigger_status_data, trigger_status_rdy, trigger_status_eof
  );
  modport slave (
    output rqst_trigger_status, trigger_status_ack,
    input  trigger_status_data, trigger_status_rdy, trigger_status_eof
  );
endinterface

// File: rtl/buffer_controller_mc_edge_detector_sel.sv
// edge_detector_sel: selects one channel and flags a rising/falling threshold crossing on each sample
module edge_detector_sel import buffer_controller_mc_pkg::*; #(
  parameter int BITS_ADC = 8,
  parameter int NUM_CH = 2,
  parameter int CH_SEL_BITS = ch_sel_bits(NUM_CH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH*BITS_ADC-1:0] sample,
  input  logic                       sample_rdy,
  input  logic [CH_SEL_BITS-1:0]     sel,
  input  logic                       edge_sel,
  input  logic [BITS_ADC-1:0]        value,
  output logic                       hit
);
  logic [BITS_ADC-1:0] cur, prev_q, prev_d;
  logic valid_q, valid_d;
  // channel mux (out-of-range falls back to channel 0) and crossing test against the previous sample
  always_comb begin
    cur = sample[0 +: BITS_ADC];
    for (int k = 1; k < NUM_CH; k++) if (sel == CH_SEL_BITS'(k)) cur = sample[k*BITS_ADC +: BITS_ADC];
    hit = sample_rdy && valid_q &&
          (edge_sel ? (prev_q > value && cur <= value) : (prev_q < value && cur >= value));
    prev_d = sample_rdy ? cur : prev_q;
    valid_d = valid_q || sample_rdy;
  end
  // previous-sample register; the first sample after release only primes it
  always_ff @(posedge clk)
    if (!rst) begin
      prev_q <= '0;
      valid_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
      valid_q <= valid_d;
    end
endmodule

// File: rtl/buffer_controller_mc.sv
// buffer_controller_mc: pre/post-trigger capture sequencer with status frames; BUFFER_CTRL_AUTO_TRIGGER_EN adds the forced trigger
module buffer_controller_mc import buffer_controller_mc_pkg::*; #(
  parameter int BITS_ADC = 8,
  parameter int NUM_CH = 2,
  parameter int COUNTER_BITS = 16,
  parameter int ADDR_BITS = 12,
  localparam int CH_SEL_BITS = ch_sel_bits(NUM_CH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH*BITS_ADC-1:0] input_sample,
  input  logic                       input_rdy,
  input  logic [COUNTER_BITS-1:0]    num_samples,
  input  logic [COUNTER_BITS-1:0]    pre_trigger,
  input  logic [BITS_ADC-1:0]        trigger_value,
  input  logic [CH_SEL_BITS-1:0]     trigger_source,
  input  logic                       trigger_edge,
  input  logic [COUNTER_BITS-1:0]    auto_timeout,
  input  logic                       start,
  input  logic                       stop,
  output logic                       write_enable,
  output logic [ADDR_BITS-1:0]       wr_addr,
  output logic [ADDR_BITS-1:0]       trigger_addr,
  buffer_controller_mc_if.master     stat
);
  state_t state_q, state_d;
  stat_state_t sst_q, sst_d;
  logic [COUNTER_BITS-1:0] cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d, trig_addr_q, trig_addr_d;
  logic full_q, full_d, trig_q, trig_d, af_q, af_d;
  logic [7:0] data_q, data_d;
  logic hit, auto_hit;
  assign write_enable = state_q != IDLE;
  assign wr_addr = wr_addr_q;
  assign trigger_addr = trig_addr_q;
  assign stat.trigger_status_data = data_q;
  assign stat.trigger_status_rdy = sst_q == S_SENDING;
  assign stat.trigger_status_eof = sst_q == S_SENDING;
  edge_detector_sel #(.BITS_ADC(BITS_ADC), .NUM_CH(NUM_CH), .CH_SEL_BITS(CH_SEL_BITS)) u_edge (
    .clk(clk), .rst(rst && state_q == WAITING_TRIGGER), .sample(input_sample), .sample_rdy(input_rdy),
    .sel(trigger_source), .edge_sel(trigger_edge), .value(trigger_value), .hit(hit)
  );
`ifdef BUFFER_CTRL_AUTO_TRIGGER_EN
  logic [COUNTER_BITS-1:0] auto_q, auto_d;
  // samples spent waiting; the sample that reaches a nonzero timeout forces the trigger
  always_comb begin
    auto_d = start ? '0 : auto_q + COUNTER_BITS'(input_rdy && state_q == WAITING_TRIGGER);
    auto_hit = input_rdy && state_q == WAITING_TRIGGER && auto_timeout != '0 && auto_q == auto_timeout - 1'b1;
  end
  // auto counter register
  always_ff @(posedge clk) auto_q <= !rst ? '0 : auto_d;
`else
  logic unused_auto;
  assign unused_auto = ^auto_timeout;
  assign auto_hit = 1'b0;
`endif
  // capture sequencer: start beats stop beats normal sequencing
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    wr_addr_d = wr_addr_q;
    trig_addr_d = trig_addr_q;
    full_d = full_q;
    trig_d = trig_q;
    af_d = af_q;
    if (start) begin
      state_d = PRE_LOADING;
      cnt_d = '0;
      wr_addr_d = '0;
      full_d = 1'b0;
      trig_d = 1'b0;
      af_d = 1'b0;
    end else if (stop) state_d = IDLE;
    else if (state_q != IDLE) begin
      cnt_d = cnt_q + COUNTER_BITS'(input_rdy && cnt_q < num_samples);
      wr_addr_d = wr_addr_q + ADDR_BITS'(input_rdy);
      if (state_q == PRE_LOADING && cnt_q == pre_trigger) state_d = WAITING_TRIGGER;
      if (state_q == WAITING_TRIGGER && cnt_q == num_samples) full_d = 1'b1;
      if (state_q == WAITING_TRIGGER && (hit || auto_hit)) begin
        state_d = POST_LOADING;
        cnt_d = pre_trigger + 1'b1;
        full_d = 1'b0;
        trig_d = 1'b1;
        af_d = !hit;
        trig_addr_d = wr_addr_q;
      end
      if (state_q == POST_LOADING && cnt_q == num_samples) begin
        state_d = IDLE;
        full_d = 1'b1;
      end
    end
  end
  // capture state and flag registers
  always_ff @(posedge clk)
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      wr_addr_q <= '0;
      trig_addr_q <= '0;
      full_q <= 1'b0;
      trig_q <= 1'b0;
      af_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wr_addr_q <= wr_addr_d;
      trig_addr_q <= trig_addr_d;
      full_q <= full_d;
      trig_q <= trig_d;
      af_q <= af_d;
    end
  // status frame: snapshot flags on request, hold until acknowledged
  always_comb begin
    sst_d = sst_q;
    data_d = data_q;
    if (sst_q == S_IDLE && stat.rqst_trigger_status) begin
      sst_d = S_SENDING;
      data_d = '0;
      data_d[ST_AUTO_FIRED] = af_q;
      data_d[ST_IDLE] = state_q == IDLE;
      data_d[ST_TRIGGERED] = trig_q;
      data_d[ST_BUFFER_FULL] = full_q;
    end else if (sst_q == S_SENDING && stat.trigger_status_ack) sst_d = S_IDLE;
  end
  // status frame registers
  always_ff @(posedge clk)
    if (!rst) begin
      sst_q <= S_IDLE;
      data_q <= '0;
    end else begin
      sst_q <= sst_d;
      data_q <= data_d;
    end
endmodule

// File: tb/tb_buffer_controller_mc.sv
// tb_buffer_controller_mc: directed capture scenarios with a status-frame scoreboard
module tb_buffer_controller_mc;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [15:0] input_sample = '0;
  logic input_rdy = 1'b0;
  logic [15:0] num_samples = '0, pre_trigger = '0, auto_timeout = '0;
  logic [7:0] trigger_value = '0;
  logic [0:0] trigger_source = '0;
  logic trigger_edge = 1'b0, start = 1'b0, stop = 1'b0;
  logic write_enable;
  logic [11:0] wr_addr, trigger_addr;
  int checks = 0, errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] held;
  buffer_controller_mc_if sif();
  buffer_controller_mc dut (
    .clk(clk), .rst(rst), .input_sample(input_sample), .input_rdy(input_rdy),
    .num_samples(num_samples), .pre_trigger(pre_trigger), .trigger_value(trigger_value),
    .trigger_source(trigger_source), .trigger_edge(trigger_edge), .auto_timeout(auto_timeout),
    .start(start), .stop(stop), .write_enable(write_enable), .wr_addr(wr_addr),
    .trigger_addr(trigger_addr), .stat(sif)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic smp(input logic [7:0] c0, input logic [7:0] c1);
    input_sample = {c1, c0};
    input_rdy = 1'b1;
    step();
    input_rdy = 1'b0;
  endtask
  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask
  task automatic pulse_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask
  task automatic config_cap(input logic src, input logic edg, input logic [15:0] pre, input logic [15:0] num,
                            input logic [15:0] at);
    trigger_source = src;
    trigger_edge = edg;
    trigger_value = 8'h80;
    pre_trigger = pre;
    num_samples = num;
    auto_timeout = at;
  endtask
  task automatic get_status(input logic [7:0] e);
    exp_q.push_back(e);
    sif.rqst_trigger_status = 1'b1;
    step();
    sif.rqst_trigger_status = 1'b0;
    chk("status_rdy", 32'(sif.trigger_status_rdy), 32'd1);
    sif.trigger_status_ack = 1'b1;
    step();
    sif.trigger_status_ack = 1'b0;
    step();
  endtask
  // scoreboard monitor: every consumed frame must match the oldest expected byte
  always @(negedge clk)
    if (rst && sif.trigger_status_rdy && sif.trigger_status_ack) begin
      if (exp_q.size() == 0) chk("unexpected_frame", 32'(sif.trigger_status_data), 32'hFFFF);
      else begin
        chk("frame_data", 32'(sif.trigger_status_data), 32'(exp_q.pop_front()));
        chk("frame_eof", 32'(sif.trigger_status_eof), 32'd1);
      end
    end
  initial begin
    sif.rqst_trigger_status = 1'b0;
    sif.trigger_status_ack = 1'b0;
    repeat (3) step();
    chk("rst_we", 32'(write_enable), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_trig_addr", 32'(trigger_addr), 0);
    chk("rst_rdy", 32'(sif.trigger_status_rdy), 0);
    chk("rst_eof", 32'(sif.trigger_status_eof), 0);
    chk("rst_data", 32'(sif.trigger_status_data), 0);
    rst = 1'b1;
    step();
    get_status(8'h04);
    // rising ramp on channel 1
    config_cap(1'b1, 1'b0, 16'd4, 16'd16, 16'd0);
    pulse_start();
    chk("t1_we_rise", 32'(write_enable), 1);
    repeat (4) smp(8'hFF, 8'h10);
    repeat (2) step();
    smp(8'hFF, 8'h70);
    smp(8'hFF, 8'h78);
    smp(8'hFF, 8'h80);
    chk("t1_trig_addr", 32'(trigger_addr), 6);
    repeat (5) smp(8'hFF, 8'h90);
    get_status(8'h02);
    repeat (6) smp(8'hFF, 8'h90);
    chk("t1_we_last", 32'(write_enable), 1);
    step();
    chk("t1_we_fall", 32'(write_enable), 0);
    chk("t1_wr_addr", 32'(wr_addr), 18);
    get_status(8'h07);
    // falling on channel 0, channel 1 crossing is ignored
    config_cap(1'b0, 1'b1, 16'd0, 16'd8, 16'd0);
    pulse_start();
    step();
    smp(8'h60, 8'h90);
    smp(8'h90, 8'h90);
    smp(8'h85, 8'h70);
    get_status(8'h00);
    smp(8'h80, 8'h70);
    chk("t2_trig_addr", 32'(trigger_addr), 3);
    repeat (7) smp(8'h50, 8'h70);
    step();
    chk("t2_we", 32'(write_enable), 0);
    chk("t2_wr_addr", 32'(wr_addr), 11);
    get_status(8'h07);
    // flat input with auto timeout 5
    config_cap(1'b0, 1'b0, 16'd2, 16'd10, 16'd5);
    pulse_start();
    repeat (2) smp(8'h50, 8'h50);
    step();
    repeat (4) smp(8'h50, 8'h50);
    get_status(8'h00);
    smp(8'h50, 8'h50);
`ifdef BUFFER_CTRL_AUTO_TRIGGER_EN
    chk("t3_trig_addr", 32'(trigger_addr), 6);
    get_status(8'h0A);
    repeat (7) smp(8'h50, 8'h50);
    step();
    chk("t3_wr_addr", 32'(wr_addr), 14);
    get_status(8'h0F);
`else
    chk("t3_no_trig_addr", 32'(trigger_addr), 3);
    repeat (3) smp(8'h50, 8'h50);
    step();
    get_status(8'h01);
    pulse_stop();
    get_status(8'h05);
`endif
    auto_timeout = '0;
    // address wrap with buffer_full sticky while waiting
    config_cap(1'b0, 1'b0, 16'd0, 16'd3, 16'd0);
    pulse_start();
    step();
    input_sample = 16'h1010;
    input_rdy = 1'b1;
    repeat (4094) step();
    input_rdy = 1'b0;
    chk("t4_wr_addr_pre", 32'(wr_addr), 4094);
    get_status(8'h01);
    smp(8'h90, 8'h10);
    chk("t4_trig_addr", 32'(trigger_addr), 12'hFFE);
    smp(8'h10, 8'h10);
    chk("t4_wrap", 32'(wr_addr), 0);
    smp(8'h10, 8'h10);
    step();
    chk("t4_wr_addr_end", 32'(wr_addr), 1);
    get_status(8'h07);
    // stop during post-load then restart
    config_cap(1'b0, 1'b0, 16'd0, 16'd8, 16'd0);
    pulse_start();
    step();
    smp(8'h10, 8'h10);
    smp(8'h90, 8'h10);
    chk("t5_trig_addr", 32'(trigger_addr), 1);
    repeat (2) smp(8'h10, 8'h10);
    pulse_stop();
    chk("t5_we_stop", 32'(write_enable), 0);
    chk("t5_wr_hold", 32'(wr_addr), 4);
    pulse_start();
    chk("t5_we_restart", 32'(write_enable), 1);
    chk("t5_wr_clear", 32'(wr_addr), 0);
    get_status(8'h00);
    pulse_stop();
    // held request with delayed ack yields one stable frame
    exp_q.push_back(8'h04);
    sif.rqst_trigger_status = 1'b1;
    step();
    chk("t6_rdy", 32'(sif.trigger_status_rdy), 1);
    held = sif.trigger_status_data;
    repeat (3) begin
      step();
      chk("t6_rdy_hold", 32'(sif.trigger_status_rdy), 1);
      chk("t6_data_stable", 32'(sif.trigger_status_data), 32'(held));
      chk("t6_eof", 32'(sif.trigger_status_eof), 1);
    end
    sif.trigger_status_ack = 1'b1;
    step();
    sif.trigger_status_ack = 1'b0;
    sif.rqst_trigger_status = 1'b0;
    chk("t6_rdy_drop", 32'(sif.trigger_status_rdy), 0);
    step();
    chk("t6_one_frame", 32'(sif.trigger_status_rdy), 0);
    // reset in the middle of a capture and a frame
    pulse_start();
    sif.rqst_trigger_status = 1'b1;
    step();
    sif.rqst_trigger_status = 1'b0;
    chk("t6_rdy_pre_rst", 32'(sif.trigger_status_rdy), 1);
    rst = 1'b0;
    step();
    chk("t6_rst_rdy", 32'(sif.trigger_status_rdy), 0);
    chk("t6_rst_eof", 32'(sif.trigger_status_eof), 0);
    chk("t6_rst_data", 32'(sif.trigger_status_data), 0);
    chk("t6_rst_we", 32'(write_enable), 0);
    chk("t6_rst_trig_addr", 32'(trigger_addr), 0);
    rst = 1'b1;
    step();
    get_status(8'h04);
    repeat (2) step();
    chk("frames_pending", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
